// File: rtl/alu_32bit.sv
// ---------------------------------------------------------------------------
// alu_32bit -- registered 32-bit bit-slice ALU
//
// Thirty-two identical one-bit slices are chained by a ripple carry. The
// function code selects add, subtract, bitwise logic or pass/invert. The
// result and carry-out of the chain are captured on every rising clk edge.
//
// Ports
//   clk   in   1   system clock, rising edge
//   rst   in   1   asynchronous active-high reset, clears R and Cout
//   A     in  32   operand A
//   B     in  32   operand B
//   F     in   3   function select (see alu_32bit_pkg::alu_func_e)
//   R     out 32   registered result
//   Cout  out  1   registered carry-out of slice 31 (0 for non-arithmetic codes)
// ---------------------------------------------------------------------------

package alu_32bit_pkg;

    typedef enum logic [2:0] {
        FUNC_ADD   = 3'b000,
        FUNC_SUB   = 3'b001,
        FUNC_AND   = 3'b010,
        FUNC_OR    = 3'b011,
        FUNC_XOR   = 3'b100,
        FUNC_NOTA  = 3'b101,
        FUNC_PASSA = 3'b110,
        FUNC_NOTB  = 3'b111
    } alu_func_e;

endpackage : alu_32bit_pkg

// ---------------------------------------------------------------------------
// alu_slice -- one bit of the ALU
//
// Ports
//   a, b   in  1   operand bits
//   cin    in  1   carry from the next-lower slice
//   f      in  3   function select
//   r      out 1   result bit
//   cout   out 1   carry to the next-higher slice (0 for logic codes)
// ---------------------------------------------------------------------------
module alu_slice
    import alu_32bit_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] f,
    output logic       r,
    output logic       cout
);

    logic b_eff_s;
    logic prop_s;

    // Subtraction is A + ~B + 1: invert B here, the +1 enters as c[0].
    always_comb begin
        b_eff_s = b;
        if (f == FUNC_SUB) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
    end

    assign prop_s = a ^ b_eff_s;

    // Per-bit result and carry for the selected function.
    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        case (f)
            FUNC_ADD, FUNC_SUB: begin
                r    = prop_s ^ cin;
                cout = (a & b_eff_s) | (cin & prop_s);
            end
            FUNC_AND:   r = a & b;
            FUNC_OR:    r = a | b;
            FUNC_XOR:   r = a ^ b;
            FUNC_NOTA:  r = ~a;
            FUNC_PASSA: r = a;
            FUNC_NOTB:  r = ~b;
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule : alu_slice

// ---------------------------------------------------------------------------
// alu_32bit -- top: slice chain plus output registers
// ---------------------------------------------------------------------------
module alu_32bit
    import alu_32bit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  F,
    output logic [31:0] R,
    output logic        Cout
);

    logic [32:0] carry_s;
    logic [31:0] result_s;
    logic        cout_next_s;
    logic [31:0] result_r;
    logic        cout_r;

    // Carry into slice 0: 1 supplies the "+1" of two's-complement subtract.
    always_comb begin
        carry_s[0] = 1'b0;
        if (F == FUNC_SUB) begin
            carry_s[0] = 1'b1;
        end else begin
            carry_s[0] = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_slice
            alu_slice u_slice (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (carry_s[gi]),
                .f    (F),
                .r    (result_s[gi]),
                .cout (carry_s[gi+1])
            );
        end
    endgenerate

    // Only ADD/SUB report the chain carry; every other code reports 0.
    always_comb begin
        cout_next_s = 1'b0;
        if ((F == FUNC_ADD) || (F == FUNC_SUB)) begin
            cout_next_s = carry_s[32];
        end else begin
            cout_next_s = 1'b0;
        end
    end

    // Output registers: load every edge, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= 32'h0000_0000;
            cout_r   <= 1'b0;
        end else begin
            result_r <= result_s;
            cout_r   <= cout_next_s;
        end
    end

    assign R    = result_r;
    assign Cout = cout_r;

endmodule : alu_32bit

// File: tb/tb_alu_32bit.sv
// ---------------------------------------------------------------------------
// tb_alu_32bit -- self-checking bench for alu_32bit
// Directed vectors with hand-computed results (also used for the latency
// check), a reset sequence, and a random sweep against a behavioural model.
// ---------------------------------------------------------------------------
module tb_alu_32bit;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  F;
    logic [31:0] R;
    logic        Cout;

    int n_compared;
    int n_mismatched;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] r;
        logic        c;
    } vec_t;

    vec_t vecs[13];

    alu_32bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .F    (F),
        .R    (R),
        .Cout (Cout)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Independent reference: 33-bit arithmetic, plain operators for logic.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [32:0] res;
        case (f)
            3'b000:  res = {1'b0, a} + {1'b0, b};
            3'b001:  res = {1'b0, a} + {1'b0, ~b} + 33'd1;
            3'b010:  res = {1'b0, a & b};
            3'b011:  res = {1'b0, a | b};
            3'b100:  res = {1'b0, a ^ b};
            3'b101:  res = {1'b0, ~a};
            3'b110:  res = {1'b0, a};
            3'b111:  res = {1'b0, ~b};
            default: res = 33'd0;
        endcase
        return res;
    endfunction

    initial begin
        logic [31:0] prev_r;
        logic        prev_c;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] exp_v;

        n_compared   = 0;
        n_mismatched = 0;

        vecs[0]  = '{"add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 32'h0000_0000, 1'b1};
        vecs[1]  = '{"add_signed",  32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 32'h8000_0000, 1'b0};
        vecs[2]  = '{"add_zero",    32'h0000_0000, 32'h0000_0000, 3'b000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"sub_nobor",   32'h8000_0000, 32'h0000_0001, 3'b001, 32'h7FFF_FFFF, 1'b1};
        vecs[4]  = '{"sub_borrow",  32'h0000_0000, 32'hFFFF_FFFF, 3'b001, 32'h0000_0001, 1'b0};
        vecs[5]  = '{"sub_equal",   32'h1234_5678, 32'h1234_5678, 3'b001, 32'h0000_0000, 1'b1};
        vecs[6]  = '{"or",          32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b011, 32'h7FFF_FFFF, 1'b0};
        vecs[7]  = '{"and",         32'h8000_0000, 32'h8000_0000, 3'b010, 32'h8000_0000, 1'b0};
        vecs[8]  = '{"xor",         32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h0FF0_0FF0, 1'b0};
        vecs[9]  = '{"nota",        32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 32'h0F0F_0F0F, 1'b0};
        vecs[10] = '{"passa",       32'hF0F0_F0F0, 32'hFF00_FF00, 3'b110, 32'hF0F0_F0F0, 1'b0};
        vecs[11] = '{"notb",        32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 32'h00FF_00FF, 1'b0};
        // Logic code whose operands would carry under ADD: Cout must stay 0.
        vecs[12] = '{"and_nocarry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFF, 1'b0};

        // Reset state
        rst = 1'b1;
        A   = 32'h0000_0000;
        B   = 32'h0000_0000;
        F   = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_value("reset_r", R, 32'h0000_0000);
        check_value("reset_cout", {31'd0, Cout}, 32'd0);
        rst = 1'b0;

        // Directed vectors, one per cycle; each also checks there is no
        // early update before the capturing edge.
        prev_r = 32'h0000_0000;
        prev_c = 1'b0;
        for (int i = 0; i < 13; i++) begin
            A = vecs[i].a;
            B = vecs[i].b;
            F = vecs[i].f;
            #2;
            check_value({vecs[i].tag, "_hold_r"}, R, prev_r);
            check_value({vecs[i].tag, "_hold_c"}, {31'd0, Cout}, {31'd0, prev_c});
            @(posedge clk);
            #1;
            check_value({vecs[i].tag, "_r"}, R, vecs[i].r);
            check_value({vecs[i].tag, "_c"}, {31'd0, Cout}, {31'd0, vecs[i].c});
            prev_r = vecs[i].r;
            prev_c = vecs[i].c;
        end

        // Reset sequence
        A = 32'hFFFF_FFFF;
        B = 32'h0000_0001;
        F = 3'b000;
        @(posedge clk);
        #1;
        check_value("rst_pre_r", R, 32'h0000_0000);
        check_value("rst_pre_c", {31'd0, Cout}, 32'd1);
        A = 32'hFFFF_FFFF;
        B = 32'hFFFF_FFFF;
        #2;
        rst = 1'b1;
        #1;
        check_value("rst_async_r", R, 32'h0000_0000);
        check_value("rst_async_c", {31'd0, Cout}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_held_r", R, 32'h0000_0000);
        check_value("rst_held_c", {31'd0, Cout}, 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_value("rst_release_r", R, 32'hFFFF_FFFE);
        check_value("rst_release_c", {31'd0, Cout}, 32'd1);

        // Random sweep: 6 operand pairs x all 8 codes
        for (int p = 0; p < 6; p++) begin
            ra = $urandom;
            rb = $urandom;
            for (int f = 0; f < 8; f++) begin
                A = ra;
                B = rb;
                F = f[2:0];
                exp_v = model(ra, rb, f[2:0]);
                @(posedge clk);
                #1;
                check_value($sformatf("rand%0d_f%0d_r", p, f), R, exp_v[31:0]);
                check_value($sformatf("rand%0d_f%0d_c", p, f), {31'd0, Cout}, {31'd0, exp_v[32]});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_alu_32bit
